// File: rtl/uart_tx_queue.sv
// Transmit byte queue between the host bus and a UART transmitter.
// Circular buffer with registered occupancy count and a sticky overflow flag.
module uart_tx_queue #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       flush,
  input  logic                       ovf_clr,
  input  logic                       tx_started,
  output logic                       queue_not_empty,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     free_cnt,
  output logic                       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overflow_q, overflow_d;

  logic pop;
  logic push;
  logic drop;
  logic mem_we;

  always_comb begin
    pop    = tx_started && (count_q != '0);
    // A pop in the same cycle frees the slot, so a full queue can still accept.
    push   = wr_en && ((count_q != DEPTH_C) || pop);
    drop   = wr_en && (count_q == DEPTH_C) && !pop;
    mem_we = push && !flush;

    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (flush) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
      // Setting wins over a simultaneous clear.
      if (drop)         overflow_d = 1'b1;
      else if (ovf_clr) overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[wr_ptr_q] <= wr_data;
  end

  assign tx_data         = mem_q[rd_ptr_q];
  assign queue_not_empty = (count_q != '0);
  assign full            = (count_q == DEPTH_C);
  assign free_cnt        = DEPTH_C - count_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: stimulus queues expected bytes,
// a negedge monitor compares tx_data on every pop the DUT presents.
module tb_uart_tx_queue;

  logic       clk;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       flush;
  logic       ovf_clr;
  logic       tx_started;
  logic       queue_not_empty;
  logic [7:0] tx_data;
  logic       full;
  logic [3:0] free_cnt;
  logic       overflow;

  uart_tx_queue #(.DEPTH(8), .WIDTH(8)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_data         (wr_data),
    .flush           (flush),
    .ovf_clr         (ovf_clr),
    .tx_started      (tx_started),
    .queue_not_empty (queue_not_empty),
    .tx_data         (tx_data),
    .full            (full),
    .free_cnt        (free_cnt),
    .overflow        (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] exp_q[$];
  int         mcount   = 0;
  logic       movf     = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: every pop the DUT shows must deliver the oldest expected byte.
  always @(negedge clk) begin
    if (rst_n && tx_started && queue_not_empty) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_pop", 32'(tx_data), 32'hffff_ffff);
      end else begin
        chk("pop_data", 32'(tx_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic chk_status(input string tag);
    chk({tag, "_qne"},  32'(queue_not_empty), 32'(mcount != 0));
    chk({tag, "_full"}, 32'(full),            32'(mcount == 8));
    chk({tag, "_free"}, 32'(free_cnt),        32'(8 - mcount));
    chk({tag, "_ovf"},  32'(overflow),        32'(movf));
  endtask

  // One clock of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic cyc(input string tag, input logic we, input logic [7:0] d,
                     input logic ts, input logic fl, input logic oc);
    bit pop_m, acc, drop;
    pop_m = ts && (mcount > 0);
    acc   = we && ((mcount < 8) || pop_m) && !fl;
    drop  = we && (mcount == 8) && !pop_m && !fl;
    wr_en = we; wr_data = d; tx_started = ts; flush = fl; ovf_clr = oc;
    @(posedge clk); #1;
    wr_en = 1'b0; tx_started = 1'b0; flush = 1'b0; ovf_clr = 1'b0;
    if (fl) begin
      exp_q.delete();
      mcount = 0;
      movf   = 1'b0;
    end else begin
      if (acc) exp_q.push_back(d);
      mcount = mcount + int'(acc) - int'(pop_m);
      if (drop)    movf = 1'b1;
      else if (oc) movf = 1'b0;
    end
    chk_status(tag);
  endtask

  task automatic push(input logic [7:0] d); cyc("push", 1'b1, d, 1'b0, 1'b0, 1'b0); endtask
  task automatic pop();                      cyc("pop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0); endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; flush = 1'b0;
    ovf_clr = 1'b0; tx_started = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_qne",  32'(queue_not_empty), 32'd0);
    chk("rst_full", 32'(full),            32'd0);
    chk("rst_free", 32'(free_cnt),        32'd8);
    chk("rst_ovf",  32'(overflow),        32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single byte round trip.
    push(8'hA5);
    chk("a5_qne",  32'(queue_not_empty), 32'd1);
    chk("a5_data", 32'(tx_data),         32'hA5);
    chk("a5_free", 32'(free_cnt),        32'd7);
    pop();
    chk("a5_pop_qne",  32'(queue_not_empty), 32'd0);
    chk("a5_pop_free", 32'(free_cnt),        32'd8);

    // Fill, overflow on ninth push, drain in order.
    for (int i = 1; i <= 8; i++) push(8'(i));
    chk("fill_full", 32'(full),     32'd1);
    chk("fill_free", 32'(free_cnt), 32'd0);
    push(8'h09);
    chk("drop_ovf",  32'(overflow), 32'd1);
    chk("drop_head", 32'(tx_data),  32'h01);
    for (int i = 0; i < 8; i++) pop();
    chk("drain_free", 32'(free_cnt), 32'd8);
    cyc("clr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(overflow), 32'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 8; i++) push(8'h10 + 8'(i));
    cyc("pushpop", 1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    chk("pp_full", 32'(full),     32'd1);
    chk("pp_ovf",  32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) pop();

    // Twenty bytes streamed through, wrapping the pointers several times.
    for (int i = 0; i < 20; i++)
      cyc("stream", 1'b1, 8'h20 + 8'(i), (mcount >= 3), 1'b0, 1'b0);
    while (mcount > 0) pop();
    chk("stream_ovf", 32'(overflow), 32'd0);

    // Pop on empty is ignored.
    pop();
    chk("empty_pop_free", 32'(free_cnt), 32'd8);
    push(8'h3C);
    chk("after_empty_data", 32'(tx_data), 32'h3C);
    pop();

    // Flush overrides a push and clears overflow.
    for (int i = 0; i < 8; i++) push(8'h40 + 8'(i));
    push(8'hEE);
    chk("pre_flush_ovf", 32'(overflow), 32'd1);
    cyc("flush", 1'b1, 8'h99, 1'b0, 1'b1, 1'b0);
    chk("flush_qne",  32'(queue_not_empty), 32'd0);
    chk("flush_ovf",  32'(overflow),        32'd0);
    chk("flush_free", 32'(free_cnt),        32'd8);

    // ovf_clr alone leaves data intact; set wins over clear in the same cycle.
    for (int i = 0; i < 8; i++) push(8'h50 + 8'(i));
    push(8'hEE);
    cyc("ovfclr", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("ovfclr_ovf",  32'(overflow), 32'd0);
    chk("ovfclr_full", 32'(full),     32'd1);
    chk("ovfclr_head", 32'(tx_data),  32'h50);
    cyc("setwins", 1'b1, 8'hEE, 1'b0, 1'b0, 1'b1);
    chk("setwins_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 8; i++) pop();
    cyc("clr2", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);

    // Asynchronous reset mid-operation discards entries immediately.
    push(8'h61); push(8'h62); push(8'h63);
    rst_n = 1'b0;
    #1;
    chk("arst_qne",  32'(queue_not_empty), 32'd0);
    chk("arst_free", 32'(free_cnt),        32'd8);
    chk("arst_full", 32'(full),            32'd0);
    exp_q.delete();
    mcount = 0;
    movf   = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    push(8'h77);
    chk("post_rst_data", 32'(tx_data), 32'h77);
    pop();

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
